// File: rtl/aes_ctr_inc_fsm_if.sv
// Request/status handshake plus the slice read/write port of the external counter register file.
interface aes_ctr_inc_fsm_if #(
   parameter int SliceSize     = 16,
   parameter int SliceIdxWidth = 3
);
   logic                     incr;
   logic [SliceSize-1:0]     incr_val;
   logic                     inc32;
   logic                     ready;
   logic                     done;
   logic                     wrap;
   logic [SliceIdxWidth-1:0] ctr_slice_idx;
   logic [SliceSize-1:0]     ctr_slice_rd;
   logic [SliceSize-1:0]     ctr_slice_wr;
   logic                     ctr_we;

   // master: control FSM plus register file; slave: the increment FSM
   modport master (
      output incr, incr_val, inc32, ctr_slice_rd,
      input  ready, done, wrap, ctr_slice_idx, ctr_slice_wr, ctr_we
   );
   modport slave (
      input  incr, incr_val, inc32, ctr_slice_rd,
      output ready, done, wrap, ctr_slice_idx, ctr_slice_wr, ctr_we
   );
endinterface

// File: rtl/aes_ctr_inc_fsm.sv
// Slice-serial counter increment (full width for CTR, inc32 for GCM), one slice per cycle with rippled carry.
// Sparse-encoded state flop; any error or illegal encoding locks into ERROR and raises alert_o.
module aes_ctr_inc_fsm #(
   parameter int CtrWidth      = 128,
   parameter int SliceSize     = 16,
   parameter int EarlyExit     = 0,
   parameter int NumSlices     = CtrWidth / SliceSize,
   parameter int SliceIdxWidth = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   aes_ctr_inc_fsm_if.slave ctr_if,
   input  logic             incr_err_i,
   input  logic             mr_err_i,
   output logic             alert_o
);
   localparam logic [5:0] StIdle  = 6'b101001;
   localparam logic [5:0] StIncr  = 6'b010110;
   localparam logic [5:0] StError = 6'b111100;

   localparam logic [SliceIdxWidth-1:0] LastIdxFull = SliceIdxWidth'(NumSlices - 1);
   localparam logic [SliceIdxWidth-1:0] LastIdx32   = SliceIdxWidth'(32 / SliceSize - 1);

   logic [5:0]               state_q, state_d;
   logic [SliceIdxWidth-1:0] idx_q, idx_d, last_idx;
   logic [SliceSize-1:0]     incr_val_q, incr_val_d, addend;
   logic [SliceSize:0]       sum;
   logic                     carry_q, carry_d;
   logic                     wrap_q, wrap_d;
   logic                     inc32_q, inc32_d;
   logic                     at_last, complete, err;

   assign last_idx = inc32_q ? LastIdx32 : LastIdxFull;
   assign at_last  = (idx_q == last_idx);
   assign addend   = (idx_q == '0) ? incr_val_q : {{(SliceSize-1){1'b0}}, carry_q};
   assign sum      = {1'b0, ctr_if.ctr_slice_rd} + {1'b0, addend};
   assign complete = at_last || ((EarlyExit != 0) && !sum[SliceSize]);
   assign err      = incr_err_i | mr_err_i;

   assign ctr_if.ctr_slice_wr  = sum[SliceSize-1:0];
   assign ctr_if.ctr_slice_idx = idx_q;
   assign ctr_if.wrap          = wrap_q;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      carry_d       = carry_q;
      wrap_d        = wrap_q;
      incr_val_d    = incr_val_q;
      inc32_d       = inc32_q;
      ctr_if.ready  = 1'b0;
      ctr_if.done   = 1'b0;
      ctr_if.ctr_we = 1'b0;
      alert_o       = 1'b0;
      case (state_q)
         StIdle: begin
            ctr_if.ready = 1'b1;
            if (ctr_if.incr) begin
               incr_val_d = ctr_if.incr_val;
               inc32_d    = ctr_if.inc32;
               idx_d      = '0;
               wrap_d     = 1'b0;
               state_d    = StIncr;
            end
         end
         StIncr: begin
            ctr_if.ctr_we = 1'b1;
            carry_d       = sum[SliceSize];
            if (complete) begin
               ctr_if.done = 1'b1;
               wrap_d      = at_last & sum[SliceSize];
               idx_d       = '0;
               state_d     = StIdle;
            end else begin
               idx_d = idx_q + SliceIdxWidth'(1);
            end
         end
         StError: alert_o = 1'b1;
         default: begin
            alert_o = 1'b1;
            state_d = StError;
         end
      endcase
      // The slice write of this cycle still lands; everything else freezes.
      if (err) begin
         state_d     = StError;
         idx_d       = idx_q;
         carry_d     = carry_q;
         wrap_d      = wrap_q;
         incr_val_d  = incr_val_q;
         inc32_d     = inc32_q;
         ctr_if.done = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         wrap_q     <= 1'b0;
         incr_val_q <= '0;
         inc32_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         wrap_q     <= wrap_d;
         incr_val_q <= incr_val_d;
         inc32_q    <= inc32_d;
      end
   end

   a_alert_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !alert_o |-> (state_q == StIdle || state_q == StIncr));
   a_we_incr: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ctr_if.ctr_we |-> (state_q == StIncr));
   a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ctr_if.done |=> !ctr_if.done);
   a_idx_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == StIncr) |-> (idx_q <= last_idx));
endmodule

// File: tb/tb_aes_ctr_inc_fsm.sv
// Directed bench: dut0 is constant-time, dut1 has early exit; each owns a modelled counter register file.
module tb_aes_ctr_inc_fsm;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   aes_ctr_inc_fsm_if #(.SliceSize(16), .SliceIdxWidth(3)) if0 ();
   aes_ctr_inc_fsm_if #(.SliceSize(16), .SliceIdxWidth(3)) if1 ();

   logic        incr_r = 1'b0;
   logic        sel = 1'b0;
   logic [15:0] val_r = '0;
   logic        inc32_r = 1'b0;
   logic        mr_err = 1'b0;
   logic        incr_err = 1'b0;
   logic        alert0, alert1;

   assign if0.incr     = incr_r & ~sel;
   assign if1.incr     = incr_r & sel;
   assign if0.incr_val = val_r;
   assign if1.incr_val = val_r;
   assign if0.inc32    = inc32_r;
   assign if1.inc32    = inc32_r;

   aes_ctr_inc_fsm #(.CtrWidth(128), .SliceSize(16), .EarlyExit(0)) dut0 (
      .clk_i(clk_i), .rst_ni(rst_ni), .ctr_if(if0.slave),
      .incr_err_i(incr_err), .mr_err_i(mr_err), .alert_o(alert0));
   aes_ctr_inc_fsm #(.CtrWidth(128), .SliceSize(16), .EarlyExit(1)) dut1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .ctr_if(if1.slave),
      .incr_err_i(1'b0), .mr_err_i(1'b0), .alert_o(alert1));

   logic [15:0] mem0 [8];
   logic [15:0] mem1 [8];
   logic [15:0] pre [8];
   int          wc0 [8];
   int          wc1 [8];
   int          base [8];
   logic        ld0 = 1'b0, ld1 = 1'b0;

   assign if0.ctr_slice_rd = mem0[if0.ctr_slice_idx];
   assign if1.ctr_slice_rd = mem1[if1.ctr_slice_idx];

   always @(posedge clk_i) begin
      if (ld0) begin
         for (int i = 0; i < 8; i++) mem0[i] <= pre[i];
      end else if (if0.ctr_we) begin
         mem0[if0.ctr_slice_idx] <= if0.ctr_slice_wr;
         wc0[if0.ctr_slice_idx]  <= wc0[if0.ctr_slice_idx] + 1;
      end
      if (ld1) begin
         for (int i = 0; i < 8; i++) mem1[i] <= pre[i];
      end else if (if1.ctr_we) begin
         mem1[if1.ctr_slice_idx] <= if1.ctr_slice_wr;
         wc1[if1.ctr_slice_idx]  <= wc1[if1.ctr_slice_idx] + 1;
      end
   end

   logic       cur_done, cur_ready, cur_wrap, cur_we;
   logic [2:0] cur_idx;
   assign cur_done  = sel ? if1.done          : if0.done;
   assign cur_ready = sel ? if1.ready         : if0.ready;
   assign cur_wrap  = sel ? if1.wrap          : if0.wrap;
   assign cur_we    = sel ? if1.ctr_we        : if0.ctr_we;
   assign cur_idx   = sel ? if1.ctr_slice_idx : if0.ctr_slice_idx;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] d, input logic [15:0] rest);
      pre[0] = a; pre[1] = b; pre[2] = c; pre[3] = d;
      for (int i = 4; i < 8; i++) pre[i] = rest;
      ld0 = ~sel;
      ld1 = sel;
      @(negedge clk_i);
      ld0 = 1'b0;
      ld1 = 1'b0;
   endtask

   task automatic snap();
      for (int i = 0; i < 8; i++) base[i] = sel ? wc1[i] : wc0[i];
   endtask

   function automatic int wdiff(input int i);
      return (sel ? wc1[i] : wc0[i]) - base[i];
   endfunction

   function automatic int wtotal();
      int t = 0;
      for (int i = 0; i < 8; i++) t += wdiff(i);
      return t;
   endfunction

   // Leaves the bench at the negedge of the first INCR cycle; hold keeps incr high and scrambles the inputs.
   task automatic start_op(input logic [15:0] v, input logic i32, input bit hold);
      snap();
      incr_r  = 1'b1;
      val_r   = v;
      inc32_r = i32;
      @(negedge clk_i);
      if (hold) begin
         val_r   = 16'hFFFF;
         inc32_r = ~i32;
      end else begin
         incr_r = 1'b0;
      end
   endtask

   task automatic finish_op(input string tag, input int exp_cycles, input logic exp_wrap);
      int c = 1;
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         check({tag, "_we"}, 32'(cur_we), 32'd1);
         check({tag, "_idx"}, 32'(cur_idx), 32'(c - 1));
         if (cur_done) seen = 1;
         else begin
            @(negedge clk_i);
            c++;
         end
      end
      incr_r = 1'b0;
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_cycles"}, 32'(c), 32'(exp_cycles));
      @(negedge clk_i);
      check({tag, "_done_width"}, 32'(cur_done), 32'd0);
      check({tag, "_ready_after"}, 32'(cur_ready), 32'd1);
      check({tag, "_wrap"}, 32'(cur_wrap), 32'(exp_wrap));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk_i);
      @(negedge clk_i);
      check("rst_ready", 32'(if0.ready), 32'd1);
      check("rst_done", 32'(if0.done), 32'd0);
      check("rst_wrap", 32'(if0.wrap), 32'd0);
      check("rst_alert", 32'(alert0), 32'd0);
      check("rst_we", 32'(if0.ctr_we), 32'd0);
      check("rst_idx", 32'(if0.ctr_slice_idx), 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Full width, all-ones counter plus 1: every slice becomes 0 and the counter wraps.
      sel = 1'b0;
      fill(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      start_op(16'h0001, 1'b0, 0);
      finish_op("full_ones", 8, 1'b1);
      for (int i = 0; i < 8; i++) check($sformatf("full_ones_m%0d", i), 32'(mem0[i]), 32'h0);
      check("full_ones_writes", 32'(wtotal()), 32'd8);

      // inc32: only slices 0 and 1 move; slice 2 must not absorb the carry.
      fill(16'hFFFF, 16'hFFFF, 16'h0000, 16'h1234, 16'hA5A5);
      start_op(16'h0001, 1'b1, 0);
      finish_op("inc32_wrap", 2, 1'b1);
      check("inc32_m0", 32'(mem0[0]), 32'h0000);
      check("inc32_m1", 32'(mem0[1]), 32'h0000);
      check("inc32_m2", 32'(mem0[2]), 32'h0000);
      check("inc32_m3", 32'(mem0[3]), 32'h1234);
      check("inc32_m7", 32'(mem0[7]), 32'hA5A5);
      check("inc32_writes", 32'(wtotal()), 32'd2);

      // inc32 without wrap: 0x0001_9000 + 0x8000 = 0x0002_1000.
      fill(16'h9000, 16'h0001, 16'h5555, 16'h5555, 16'h5555);
      start_op(16'h8000, 1'b1, 0);
      finish_op("inc32_nowrap", 2, 1'b0);
      check("inc32n_m0", 32'(mem0[0]), 32'h1000);
      check("inc32n_m1", 32'(mem0[1]), 32'h0002);
      check("inc32n_m2", 32'(mem0[2]), 32'h5555);

      // Carry from slice 0 into slice 1, higher slices rewritten unchanged.
      fill(16'hFFFE, 16'h0007, 16'h1111, 16'h2222, 16'h3333);
      start_op(16'h0005, 1'b0, 0);
      finish_op("carry", 8, 1'b0);
      check("carry_m0", 32'(mem0[0]), 32'h0003);
      check("carry_m1", 32'(mem0[1]), 32'h0008);
      check("carry_m2", 32'(mem0[2]), 32'h1111);
      check("carry_m5", 32'(mem0[5]), 32'h3333);
      check("carry_writes", 32'(wtotal()), 32'd8);

      // Zero increment; incr held high and inputs scrambled during INCR must not matter.
      fill(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      start_op(16'h0000, 1'b0, 1);
      finish_op("zero_hold", 8, 1'b0);
      check("zero_m0", 32'(mem0[0]), 32'hFFFF);
      check("zero_m7", 32'(mem0[7]), 32'hFFFF);
      check("zero_writes", 32'(wtotal()), 32'd8);

      // Early exit: stops after the first slice that produces no carry.
      sel = 1'b1;
      fill(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      start_op(16'h0001, 1'b0, 0);
      finish_op("ee_one", 1, 1'b0);
      check("ee_one_m0", 32'(mem1[0]), 32'h0002);
      check("ee_one_writes", 32'(wtotal()), 32'd1);
      fill(16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 16'h0000);
      start_op(16'h0001, 1'b0, 0);
      finish_op("ee_two", 2, 1'b0);
      check("ee_two_m0", 32'(mem1[0]), 32'h0000);
      check("ee_two_m1", 32'(mem1[1]), 32'h0006);
      check("ee_two_writes", 32'(wtotal()), 32'd2);
      check("ee_alert", 32'(alert1), 32'd0);

      // Control-path error at idx 3: that write lands, then ERROR is terminal.
      sel = 1'b0;
      fill(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      start_op(16'h0001, 1'b0, 0);
      repeat (3) @(negedge clk_i);
      check("err_at_idx", 32'(if0.ctr_slice_idx), 32'd3);
      mr_err = 1'b1;
      @(negedge clk_i);
      mr_err = 1'b0;
      check("err_alert", 32'(alert0), 32'd1);
      check("err_we", 32'(if0.ctr_we), 32'd0);
      check("err_ready", 32'(if0.ready), 32'd0);
      incr_r = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         check("err_hold_alert", 32'(alert0), 32'd1);
         check("err_hold_we", 32'(if0.ctr_we), 32'd0);
         check("err_hold_done", 32'(if0.done), 32'd0);
      end
      incr_r = 1'b0;
      check("err_writes", 32'(wtotal()), 32'd4);
      check("err_idx3_written", 32'(wdiff(3)), 32'd1);
      check("err_idx4_untouched", 32'(wdiff(4)), 32'd0);
      check("err_m0", 32'(mem0[0]), 32'h0001);
      rst_ni = 1'b0;
      #1;
      check("err_rst_ready", 32'(if0.ready), 32'd1);
      check("err_rst_alert", 32'(alert0), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Asynchronous reset at idx 4 leaves a partial result, then a fresh op restarts at idx 0.
      fill(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      start_op(16'h0003, 1'b0, 0);
      repeat (4) @(negedge clk_i);
      check("rst_mid_idx", 32'(if0.ctr_slice_idx), 32'd4);
      rst_ni = 1'b0;
      #1;
      check("rst_mid_ready", 32'(if0.ready), 32'd1);
      check("rst_mid_we", 32'(if0.ctr_we), 32'd0);
      check("rst_mid_idx0", 32'(if0.ctr_slice_idx), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      check("rst_mid_writes", 32'(wtotal()), 32'd4);
      check("rst_mid_m0", 32'(mem0[0]), 32'h0003);
      start_op(16'h0002, 1'b0, 0);
      finish_op("restart", 8, 1'b0);
      check("restart_m0", 32'(mem0[0]), 32'h0005);
      check("restart_writes", 32'(wtotal()), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
